// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: snoops core commits into a FWFT trace buffer, counts cycles/retired instructions, detects jump-to-self halt.
// Ports: clk/reset (async active-low)/clear (sync); en gates tracing; curr_addr/new_addr/instr/reg_wr/waddr/wdata snoop the core;
// rd_* is the FWFT head with rd_ready pop; count/overflow/halted/cycle_cnt/instret_cnt report status.
module commit_trace_monitor #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int WRAP        = 0,
  parameter int HALT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  logic [XLEN-1:0]        curr_addr,
  input  logic [XLEN-1:0]        new_addr,
  input  logic [31:0]            instr,
  input  logic                   reg_wr,
  input  logic [4:0]             waddr,
  input  logic [XLEN-1:0]        wdata,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [XLEN-1:0]        rd_pc,
  output logic [4:0]             rd_waddr,
  output logic [XLEN-1:0]        rd_wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   halted,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       instret_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CONE = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);
  localparam logic [SW-1:0] SONE = SW'(1);
  localparam logic [SW-1:0] HC   = SW'(HALT_CYCLES);
  logic [XLEN-1:0]  r_pc [DEPTH];
  logic [4:0]       r_wa [DEPTH];
  logic [XLEN-1:0]  r_wd [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_count;
  logic [SW-1:0]    r_streak;
  logic             r_ovf, r_halt;
  logic [CNT_W-1:0] r_cyc, r_ins;
  logic             w_active, w_push, w_pop, w_full, w_wr, w_adv;
  assign w_active = en && !r_halt;
  assign w_push   = w_active && reg_wr && (waddr != 5'd0);
  assign w_pop    = rd_valid && rd_ready;
  assign w_full   = r_count == FULL;
  // A full buffer still accepts a push when a pop frees the slot, or when wrapping over the oldest entry.
  assign w_wr     = w_push && (!w_full || w_pop || (WRAP != 0));
  assign w_adv    = w_pop || (w_push && w_full && (WRAP != 0));
  assign rd_valid    = r_count != '0;
  assign rd_pc       = rd_valid ? r_pc[r_rp] : '0;
  assign rd_waddr    = rd_valid ? r_wa[r_rp] : '0;
  assign rd_wdata    = rd_valid ? r_wd[r_rp] : '0;
  assign count       = r_count;
  assign overflow    = r_ovf;
  assign halted      = r_halt;
  assign cycle_cnt   = r_cyc;
  assign instret_cnt = r_ins;
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_pc[r_wp] <= curr_addr;
      r_wa[r_wp] <= waddr;
      r_wd[r_wp] <= wdata;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_halt   <= 1'b0;
      r_streak <= '0;
      r_cyc    <= '0;
      r_ins    <= '0;
    end else if (clear) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_halt   <= 1'b0;
      r_streak <= '0;
      r_cyc    <= '0;
      r_ins    <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + PONE;
      if (w_adv) r_rp <= r_rp + PONE;
      if (w_wr && !w_adv) r_count <= r_count + CONE;
      else if (w_adv && !w_wr) r_count <= r_count - CONE;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_active) begin
        r_cyc <= r_cyc + CNT_W'(r_cyc != '1);
        r_ins <= r_ins + CNT_W'((instr != 32'h0) && (r_ins != '1));
        if (new_addr == curr_addr) begin
          r_streak <= r_streak + SONE;
          if (r_streak + SONE == HC) r_halt <= 1'b1;
        end else begin
          r_streak <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb_commit_trace_monitor: self-checking bench for commit_trace_monitor (drop and wrap variants side by side).
module tb_commit_trace_monitor;
  logic        clk = 1'b0, reset = 1'b0, clear = 1'b0, en = 1'b1;
  logic [31:0] curr_addr = '0, new_addr = 32'h4, instr = '0, wdata = '0;
  logic        reg_wr = 1'b0, rd_ready = 1'b0;
  logic [4:0]  waddr = '0;
  logic        rd_valid0, rd_valid1, overflow0, overflow1, halted0, halted1;
  logic [31:0] rd_pc0, rd_pc1, rd_wdata0, rd_wdata1, cyc0, cyc1, ins0, ins1;
  logic [4:0]  rd_waddr0, rd_waddr1;
  logic [2:0]  count0, count1;
  int          checks = 0, errors = 0;
  logic [68:0] q0[$], q1[$];
  logic        mh = 1'b0;
  int          streak = 0;

  always #5 clk = ~clk;

  commit_trace_monitor #(.XLEN(32), .DEPTH(4), .CNT_W(32), .WRAP(0), .HALT_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .curr_addr(curr_addr), .new_addr(new_addr),
    .instr(instr), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata), .rd_ready(rd_ready),
    .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_waddr(rd_waddr0), .rd_wdata(rd_wdata0), .count(count0),
    .overflow(overflow0), .halted(halted0), .cycle_cnt(cyc0), .instret_cnt(ins0));

  commit_trace_monitor #(.XLEN(32), .DEPTH(4), .CNT_W(32), .WRAP(1), .HALT_CYCLES(2)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .curr_addr(curr_addr), .new_addr(new_addr),
    .instr(instr), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata), .rd_ready(rd_ready),
    .rd_valid(rd_valid1), .rd_pc(rd_pc1), .rd_waddr(rd_waddr1), .rd_wdata(rd_wdata1), .count(count1),
    .overflow(overflow1), .halted(halted1), .cycle_cnt(cyc1), .instret_cnt(ins1));

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: scoreboard pops are compared before the edge, the queues are updated, and counts are checked after it.
  task automatic cyc();
    logic act, psh;
    act = en && !mh;
    psh = act && reg_wr && (waddr != 5'd0);
    if (clear) begin
      q0.delete(); q1.delete(); mh = 1'b0; streak = 0;
    end else begin
      if (rd_ready && q0.size() > 0) begin
        chk("sb_pop0", {rd_pc0, rd_waddr0, rd_wdata0}, q0[0]);
        void'(q0.pop_front());
      end
      if (rd_ready && q1.size() > 0) begin
        chk("sb_pop1", {rd_pc1, rd_waddr1, rd_wdata1}, q1[0]);
        void'(q1.pop_front());
      end
      if (psh) begin
        if (q0.size() < 4) q0.push_back({curr_addr, waddr, wdata});
        if (q1.size() == 4) void'(q1.pop_front());
        q1.push_back({curr_addr, waddr, wdata});
      end
      if (act) begin
        if (new_addr == curr_addr) begin
          streak++;
          if (streak == 2) mh = 1'b1;
        end else streak = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("sb_count0", 69'(count0), 69'(q0.size()));
    chk("sb_count1", 69'(count1), 69'(q1.size()));
    chk("sb_valid0", 69'(rd_valid0), 69'(q0.size() != 0));
    chk("sb_halted", 69'({halted0, halted1}), 69'({mh, mh}));
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
                       input logic [31:0] npc, input logic [31:0] ins, input logic rdy);
    reg_wr = w; waddr = a; wdata = d; curr_addr = pc; new_addr = npc; instr = ins; rd_ready = rdy;
    cyc();
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] d;
    logic        rdy;
    int          cnt;
    logic        ovf;
    logic [31:0] h0;
    logic [31:0] h1;
  } vec_t;
  vec_t vt[10];

  initial begin
    vt[0] = '{1'b1, 32'd1, 1'b0, 1, 1'b0, 32'd1, 32'd1};
    vt[1] = '{1'b1, 32'd2, 1'b0, 2, 1'b0, 32'd1, 32'd1};
    vt[2] = '{1'b1, 32'd3, 1'b0, 3, 1'b0, 32'd1, 32'd1};
    vt[3] = '{1'b1, 32'd4, 1'b0, 4, 1'b0, 32'd1, 32'd1};
    vt[4] = '{1'b1, 32'd5, 1'b0, 4, 1'b1, 32'd1, 32'd2};
    vt[5] = '{1'b1, 32'd6, 1'b0, 4, 1'b1, 32'd1, 32'd3};
    vt[6] = '{1'b0, 32'd0, 1'b1, 3, 1'b1, 32'd2, 32'd4};
    vt[7] = '{1'b0, 32'd0, 1'b1, 2, 1'b1, 32'd3, 32'd5};
    vt[8] = '{1'b0, 32'd0, 1'b1, 1, 1'b1, 32'd4, 32'd6};
    vt[9] = '{1'b0, 32'd0, 1'b1, 0, 1'b1, 32'd0, 32'd0};

    #12;
    chk("rst_count", 69'({count0, count1}), 69'(0));
    chk("rst_valid", 69'({rd_valid0, rd_valid1}), 69'(0));
    chk("rst_flags", 69'({overflow0, halted0, overflow1, halted1}), 69'(0));
    chk("rst_cnts", 69'({cyc0, ins0}), 69'(0));
    chk("rst_head", 69'({rd_pc0, rd_waddr0, rd_wdata0}), 69'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    reg_wr = 1'b1; waddr = 5'd1; wdata = 32'd5; curr_addr = 32'h0; new_addr = 32'h4;
    #1 chk("latency_pre", 69'(rd_valid0), 69'(0));
    drive(1'b1, 5'd1, 32'd5, 32'h0, 32'h4, 32'h13, 1'b0);
    chk("latency_post", 69'(rd_valid0), 69'(1));
    drive(1'b1, 5'd2, 32'd7, 32'h4, 32'h8, 32'h13, 1'b0);
    drive(1'b1, 5'd0, 32'd9, 32'h8, 32'hc, 32'h13, 1'b0);
    chk("x0_count", 69'(count0), 69'(2));
    chk("x0_head", {rd_pc0, rd_waddr0, rd_wdata0}, {32'h0, 5'd1, 32'd5});

    clear = 1'b1; drive(1'b0, 5'd0, 32'd0, 32'h0, 32'h4, 32'h13, 1'b0); clear = 1'b0;
    for (int k = 0; k < 10; k++)
      drive(1'b0, 5'd0, 32'd0, 32'h20 + 32'(4*k), 32'h24 + 32'(4*k), (k == 3 || k == 7) ? 32'h0 : 32'h13, 1'b0);
    chk("run_cyc", 69'(cyc0), 69'(10));
    chk("run_ins", 69'(ins0), 69'(8));
    drive(1'b0, 5'd0, 32'd0, 32'h40, 32'h40, 32'h13, 1'b0);
    chk("self1_halted", 69'(halted0), 69'(0));
    chk("self1_cnts", 69'({cyc0, ins0}), 69'({32'd11, 32'd9}));
    drive(1'b1, 5'd3, 32'h33, 32'h40, 32'h40, 32'h13, 1'b0);
    chk("self2_halted", 69'(halted0), 69'(1));
    chk("self2_cnts", 69'({cyc0, ins0}), 69'({32'd12, 32'd10}));
    chk("halt_capture", 69'(count0), 69'(1));
    drive(1'b1, 5'd4, 32'h44, 32'h40, 32'h40, 32'h13, 1'b0);
    chk("frozen_cnts", 69'({cyc1, ins1}), 69'({32'd12, 32'd10}));
    chk("frozen_count", 69'(count0), 69'(1));
    drive(1'b1, 5'd4, 32'h44, 32'h40, 32'h40, 32'h13, 1'b1);
    chk("halt_drain", 69'(count0), 69'(0));
    drive(1'b1, 5'd4, 32'h44, 32'h40, 32'h40, 32'h13, 1'b0);
    chk("refill_blocked", 69'(count0), 69'(0));

    clear = 1'b1; drive(1'b1, 5'd5, 32'h55, 32'h40, 32'h40, 32'h13, 1'b0); clear = 1'b0;
    chk("clr_all", 69'({count0, rd_valid0, overflow0, halted0}), 69'(0));
    chk("clr_cnts", 69'({cyc0, ins0}), 69'(0));
    drive(1'b0, 5'd0, 32'd0, 32'h80, 32'h84, 32'h13, 1'b0);
    chk("clr_resume", 69'({cyc0, ins0}), 69'({32'd1, 32'd1}));
    en = 1'b0;
    drive(1'b1, 5'd6, 32'h66, 32'h84, 32'h88, 32'h13, 1'b0);
    chk("en0_freeze", 69'({cyc0, ins0, count0}), 69'({32'd1, 32'd1, 3'd0}));
    en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].wr, vt[i].d[4:0], vt[i].d, 32'h100 + (vt[i].d << 2), 32'h104 + (vt[i].d << 2), 32'h13, vt[i].rdy);
      chk($sformatf("vec%0d_count", i), 69'({count0, count1}), 69'({vt[i].cnt[2:0], vt[i].cnt[2:0]}));
      chk($sformatf("vec%0d_ovf", i), 69'({overflow0, overflow1}), 69'({vt[i].ovf, vt[i].ovf}));
      chk($sformatf("vec%0d_head", i), 69'({rd_wdata0, rd_wdata1}), 69'({vt[i].h0, vt[i].h1}));
    end

    clear = 1'b1; drive(1'b0, 5'd0, 32'd0, 32'h0, 32'h4, 32'h13, 1'b0); clear = 1'b0;
    for (int k = 1; k <= 4; k++) drive(1'b1, 5'(k), 32'(10 + k), 32'(4*k), 32'(4*k + 4), 32'h13, 1'b0);
    drive(1'b1, 5'd5, 32'd15, 32'h14, 32'h18, 32'h13, 1'b1);
    chk("pp_count", 69'({count0, count1}), 69'({3'd4, 3'd4}));
    chk("pp_ovf", 69'({overflow0, overflow1}), 69'(0));
    chk("pp_head", 69'({rd_wdata0, rd_wdata1}), 69'({32'd12, 32'd12}));

    drive(1'b0, 5'd0, 32'd0, 32'h18, 32'h1c, 32'h13, 1'b1);
    chk("drain_step", 69'(count0), 69'(3));
    reset = 1'b0;
    #1;
    chk("mid_reset_count", 69'({count0, count1}), 69'(0));
    chk("mid_reset_head", 69'({rd_valid0, rd_wdata0}), 69'(0));
    q0.delete(); q1.delete(); mh = 1'b0; streak = 0;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'h0, 32'h4, 32'h13, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
